sync_fifo_lvl: RTL and testbench
================================

# sync_fifo_lvl

Parametrised synchronous FIFO with first-word fall-through reads, occupancy count, programmable almost-full and almost-empty thresholds, a flush control, and sticky overflow/underflow error flags. It is the next-generation buffer for the UART TX and RX data paths. Status outputs are derived from registered state, so the interrupt and line-status logic can sample them directly.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_THRESH`, 12, `o_almost_full` asserts when count ≥ AF_THRESH; range 1..DEPTH
- `AE_THRESH`, 2, `o_almost_empty` asserts when count ≤ AE_THRESH; range 0..DEPTH-1

- `i_clk`  in  1  clock; all logic on the rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_wr_data`  in  WIDTH  write data
- `i_wr`  in  1  write request
- `i_rd`  in  1  read request; pops the word currently on `o_rd_data`
- `i_flush`  in  1  discard all contents (synchronous)
- `i_clr_err`  in  1  clear sticky error flags
- `o_rd_data`  out  WIDTH  head-of-queue word (fall-through)
- `o_count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `o_full`, `o_empty`  out  1  count==DEPTH / count==0
- `o_almost_full`, `o_almost_empty`  out  1  threshold flags
- `o_overflow`, `o_underflow`  out  1  sticky error flags

## Operation
- Storage: DEPTH×WIDTH array, not reset. Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes wrap. The index is the low $clog2(DEPTH) bits and wraps DEPTH-1→0.
- `o_count` is held in a register, updated each cycle by +1 (write only), −1 (read only) or 0. The full, empty and threshold flags are decoded combinationally from the registered count.
- Accepted write: `i_wr` and (not full, or a read is accepted in the same cycle).
- Accepted read: `i_rd` and not empty.
- Priority, highest first:
  - `i_rst`: pointers, count and error flags cleared.
  - `i_flush`: pointers and count cleared. Same-cycle wr/rd are ignored and raise no error. Sticky flags are unaffected.
  - Normal wr/rd.
- Simultaneous wr+rd:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected, underflow set, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- `o_overflow` sets on `i_wr` with the write not accepted. `o_underflow` sets on `i_rd` with the FIFO empty.
- `i_clr_err` clears both flags. A new error event in the same cycle wins, so the flag stays 1.
- `o_rd_data` = mem[rd index], combinational from the pointer. The value is undefined while empty; benches must not check it then.

## Timing
- Reset values: `o_count`=0, `o_empty`=1, `o_full`=0, `o_almost_empty`=1, `o_almost_full`=0, `o_overflow`=0, `o_underflow`=0.
- Write-to-read latency: a word written at edge N is on `o_rd_data` and `o_empty`=0 after edge N, so it can be popped in cycle N+1.
- Read: `o_rd_data` shows the next word immediately after the edge that accepts the read.
- All status flags change only on clock edges, in the same cycle as the count change.
- Error flags assert after the edge of the offending request.
- Reset or flush mid-stream: the queue is empty after the edge. Data written before it is never readable.

## Configuration
- `SYNC_FIFO_ERR_FLAGS_EN`
  - Defined: sticky overflow/underflow logic and `i_clr_err` are implemented as described.
  - Undefined: `o_overflow` and `o_underflow` are tied to 0, `i_clr_err` is ignored, and no flag registers are built.
  - FIFO data behaviour is identical either way.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles → count 1,2,3; `o_rd_data`=0x11 one cycle after the first write. Reading 3 times yields 0x11, 0x22, 0x33, then `o_empty`=1 and `o_almost_empty`=1.
- DEPTH=16: write 16 words → `o_almost_full` asserts when count reaches 12, `o_full` at 16. A 17th write → data dropped, `o_overflow`=1, count 16.
- Full FIFO, wr(0xAA)+rd in one cycle → count stays 16, no overflow. After draining, 0xAA is read last.
- Empty FIFO, wr(0x5C)+rd in one cycle → count 1, `o_underflow`=1, `o_rd_data`=0x5C.
- Count=5, assert `i_flush` with `i_wr`=1 → count 0, `o_empty`=1, no error. Then assert `i_clr_err` in the same cycle as an overflow → flag remains 1.
- 40 write/read pairs with DEPTH=16 (pointer wrap) → data order preserved. Repeat the run with the macro undefined → error outputs always 0.

Source files
------------

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: synchronous FIFO with first-word fall-through reads,
// registered occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and optional sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN builds the sticky error
// flags and honours i_clr_err; without it both error outputs are tied low.
module sync_fifo_lvl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr,
  input  logic                     i_rd,
  input  logic                     i_flush,
  input  logic                     i_clr_err,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_ok, rd_ok;

  // Status flags decode straight from the registered count
  assign o_count        = count_q;
  assign o_full         = (count_q == CW'(DEPTH));
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= CW'(AF_THRESH));
  assign o_almost_empty = (count_q <= CW'(AE_THRESH));

  // A read frees a slot this cycle, so a full FIFO still takes a write
  // when it is popped in the same cycle. Flush suppresses both.
  assign rd_ok = i_rd && !o_empty && !i_flush;
  assign wr_ok = i_wr && (!o_full || rd_ok) && !i_flush;

  // Fall-through head word; undefined content while empty
  assign o_rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_ok) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Pointers and occupancy count; reset beats flush beats normal traffic
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  logic ovf_evt, unf_evt;

  // Requests dropped during a flush are not errors
  assign ovf_evt = i_wr && !wr_ok && !i_flush;
  assign unf_evt = i_rd && o_empty && !i_flush;

  // Sticky error flags; a same-cycle new event outranks the clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt | (ovf_q & ~i_clr_err);
      unf_q <= unf_evt | (unf_q & ~i_clr_err);
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clr_err;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: directed + random stimulus against a queue-based model.
module tb_sync_fifo_lvl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst, i_wr, i_rd, i_flush, i_clr_err;
  logic [WIDTH-1:0] i_wr_data;
  logic [WIDTH-1:0] o_rd_data;
  logic [CW-1:0]    o_count;
  logic             o_full, o_empty, o_almost_full, o_almost_empty;
  logic             o_overflow, o_underflow;

  sync_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_data(i_wr_data), .i_wr(i_wr),
    .i_rd(i_rd), .i_flush(i_flush), .i_clr_err(i_clr_err),
    .o_rd_data(o_rd_data), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty), .o_almost_full(o_almost_full),
    .o_almost_empty(o_almost_empty), .o_overflow(o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a plain queue plus two sticky bits
  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_unf;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit fl, input bit wr, input bit rd,
                            input logic [WIDTH-1:0] d, input bit clr);
    bit was_empty, was_full, rd_acc, wr_acc;
    if (rst) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      rd_acc    = rd && !was_empty;
      wr_acc    = wr && (!was_full || rd_acc);
      if (rd_acc) void'(q.pop_front());
      if (wr_acc) q.push_back(d);
      m_ovf = (wr && !wr_acc) || (m_ovf && !clr);
      m_unf = (rd && was_empty) || (m_unf && !clr);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(o_count), 32'(n));
    chk({tag, ":empty"}, 32'(o_empty), 32'(n == 0));
    chk({tag, ":full"},  32'(o_full),  32'(n == DEPTH));
    chk({tag, ":ae"},    32'(o_almost_empty), 32'(n <= AE));
    chk({tag, ":af"},    32'(o_almost_full),  32'(n >= AF));
    chk({tag, ":ovf"},   32'(o_overflow),  32'(ERR_EN && m_ovf));
    chk({tag, ":unf"},   32'(o_underflow), 32'(ERR_EN && m_unf));
    if (n != 0) chk({tag, ":data"}, 32'(o_rd_data), 32'(q[0]));
  endtask

  // One clock: drive, clock, update model, check 1 time unit later
  task automatic step(input string tag, input bit rst, input bit fl, input bit wr,
                      input bit rd, input logic [WIDTH-1:0] d, input bit clr);
    i_rst = rst; i_flush = fl; i_wr = wr; i_rd = rd; i_wr_data = d; i_clr_err = clr;
    @(posedge i_clk);
    model_edge(rst, fl, wr, rd, d, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    i_rst = 1; i_flush = 0; i_wr = 0; i_rd = 0; i_wr_data = '0; i_clr_err = 0;
    #1;
    step("reset0", 1, 0, 0, 0, 8'h00, 0);
    step("reset1", 1, 0, 0, 0, 8'h00, 0);

    // three writes then three reads, fall-through order
    for (int i = 0; i < 3; i++) step("wr3", 0, 0, 1, 0, pat[i], 0);
    for (int i = 0; i < 3; i++) step("rd3", 0, 0, 0, 1, 8'h00, 0);

    // fill to full, thresholds, then overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 0, 0, 1, 0, 8'(8'hA0 + i), 0);
    step("ovf", 0, 0, 1, 0, 8'hEE, 0);
    // full wr+rd: both accepted, no new overflow (clear old one first)
    step("clr", 0, 0, 0, 0, 8'h00, 1);
    step("fullwrrd", 0, 0, 1, 1, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 0, 1, 8'h00, 0);

    // empty wr+rd: write lands, underflow
    step("emptywrrd", 0, 0, 1, 1, 8'h5C, 0);
    step("rd5c", 0, 0, 0, 1, 8'h00, 0);

    // count 5, flush with a write: empty, no new error
    step("clr2", 0, 0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step("wr5", 0, 0, 1, 0, 8'(i), 0);
    step("flush", 0, 1, 1, 0, 8'h77, 0);
    step("flushrd", 0, 1, 0, 1, 8'h00, 0);

    // clear in same cycle as overflow keeps the flag
    for (int i = 0; i < DEPTH; i++) step("refill", 0, 0, 1, 0, 8'(8'h40 + i), 0);
    step("ovf_clr", 0, 0, 1, 0, 8'h99, 1);
    step("clr3", 0, 0, 0, 0, 8'h00, 1);
    step("reset2", 1, 0, 0, 0, 8'h00, 0);

    // 40 write/read pairs, pointer wrap
    for (int i = 0; i < 40; i++) begin
      step("pair_w", 0, 0, 1, 0, 8'($urandom), 0);
      step("pair_r", 0, 0, 0, 1, 8'h00, 0);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit fl, clr;
      fl  = ($urandom_range(0, 49) == 0);
      clr = !fl && ($urandom_range(0, 19) == 0);
      step("rand", ($urandom_range(0, 199) == 0), fl,
           ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           8'($urandom), clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
